aes_iter_core: RTL and testbench



---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_iter_core_if.sv | 21 ++
 rtl/aes_key_step.sv | 54 +++++
 rtl/aes_round_ops.sv | 37 +++
 rtl/aes_iter_core.sv | 96 +++++++++
 tb/tb_aes_iter_core.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, round count, GF(2^8) helpers, S-box, Rcon.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

  function automatic int nr(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant word, byte in the MSB; index 1..10.
  function automatic logic [31:0] rcon_word(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block-in / block-out handshake bundle of the iterative AES core.
interface aes_iter_core_if #(parameter int KEY_BITS = 128);
  logic                in_valid;
  logic                in_ready;
  logic [0:127]        plaintext;
  logic [0:KEY_BITS-1] key;
  logic                out_valid;
  logic                out_ready;
  logic [0:127]        ciphertext;
  logic                busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes_key_step.sv
// On-the-fly key expansion: next round key and next key window from kw and rnd.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic [255:0] kw,
  input  logic [3:0]   rnd,
  output logic [127:0] rk,
  output logic [255:0] kw_next
);
  logic [31:0] w0, w1, w3, w2, w7, t, n0, n1, n2, n3;

  assign w0 = kw[255:224];
  assign w1 = kw[223:192];
  assign w2 = kw[191:160];
  assign w3 = kw[159:128];
  assign w7 = kw[31:0];

  // AES-128 keeps four words in the upper half; AES-256 slides an 8-word window.
  always_comb begin
    t       = '0;
    n0      = '0;
    n1      = '0;
    n2      = '0;
    n3      = '0;
    rk      = '0;
    kw_next = kw;
    if (KEY_BITS == 256) begin
      if (rnd <= 4'd1) begin
        // Round 1 uses the second key half untouched; the window stays put.
        rk      = kw[127:0];
        kw_next = kw;
      end else begin
        if (!rnd[0]) t = sub_word(rot_word(w7)) ^ rcon_word({1'b0, rnd[3:1]});
        else         t = sub_word(w7);
        n0      = w0 ^ t;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        rk      = {n0, n1, n2, n3};
        kw_next = {kw[127:0], n0, n1, n2, n3};
      end
    end else begin
      t       = sub_word(rot_word(w3)) ^ rcon_word(rnd);
      n0      = w0 ^ t;
      n1      = w1 ^ n0;
      n2      = w2 ^ n1;
      n3      = w3 ^ n2;
      rk      = {n0, n1, n2, n3};
      kw_next = {n0, n1, n2, n3, 128'h0};
    end
  end
endmodule

// File: rtl/aes_round_ops.sv
// Round transforms. State is 128 bits with byte 0 in the MSBs, column-major.
module sub_byte
  import aes_pkg::*;
(
  input  logic [127:0] blk,
  output logic [127:0] res
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign res[8*i +: 8] = sbox(blk[8*i +: 8]);
  end
endmodule

module shift_row (
  input  logic [127:0] blk,
  output logic [127:0] res
);
  // Row r of column c takes row r of column (c + r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign res[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module mix_col
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] res
);
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;
  assign res[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign res[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign res[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign res[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor: one round per clock, key expanded on the fly.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input logic            clk,
  input logic            rst_n,
  aes_iter_core_if.slave bus
);
  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  localparam logic [3:0] NR4 = 4'(nr(KEY_BITS));

  aes_state_e   state, state_nxt;
  logic [127:0] state_reg, ct_reg, sb, sr, mc, rk, round_out;
  logic [255:0] kw, kw_next, key_ext;
  logic [3:0]   rnd;
  logic         ready, accept, last;

  sub_byte  u_sub_byte  (.blk(state_reg), .res(sb));
  shift_row u_shift_row (.blk(sb), .res(sr));

  for (genvar c = 0; c < 4; c++) begin : g_mix
    mix_col u_mix_col (.col(sr[127-32*c -: 32]), .res(mc[127-32*c -: 32]));
  end

  aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .kw     (kw),
    .rnd    (rnd),
    .rk     (rk),
    .kw_next(kw_next)
  );

  assign last      = (rnd == NR4);
  assign round_out = (last ? sr : mc) ^ rk;

  // Key left-aligned in a 256-bit window, zero-padded for AES-128.
  always_comb begin
    key_ext = '0;
    key_ext[255 -: KEY_BITS] = bus.key;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake decode; DONE can hand off and accept on one edge.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_nxt = ROUND;
      end
      ROUND: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready = bus.out_ready;
        if (bus.out_ready) state_nxt = bus.in_valid ? ROUND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = bus.in_valid && ready;
  end

  // Round datapath, key window, round counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      kw        <= '0;
      rnd       <= '0;
      ct_reg    <= '0;
    end else if (accept) begin
      state_reg <= bus.plaintext ^ key_ext[255:128];
      kw        <= key_ext;
      rnd       <= 4'd1;
    end else if (state == ROUND) begin
      state_reg <= round_out;
      kw        <= kw_next;
      rnd       <= rnd + 4'd1;
      if (last) ct_reg <= round_out;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state == ROUND);
  assign bus.ciphertext = ct_reg;
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors on an AES-128 and an AES-256 instance.
module tb_aes_iter_core;

  typedef struct {
    bit           is256;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t tbl[5];

  aes_iter_core_if #(.KEY_BITS(128)) b128 ();
  aes_iter_core_if #(.KEY_BITS(256)) b256 ();

  aes_iter_core #(.KEY_BITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .bus(b128.slave));
  aes_iter_core #(.KEY_BITS(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(b256.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit s, input logic v, input logic [255:0] k, input logic [127:0] p);
    if (s) begin
      b256.in_valid  = v;
      b256.key       = k;
      b256.plaintext = p;
    end else begin
      b128.in_valid  = v;
      b128.key       = k[255:128];
      b128.plaintext = p;
    end
  endtask

  task automatic set_or(input bit s, input logic v);
    if (s) b256.out_ready = v;
    else   b128.out_ready = v;
  endtask

  function automatic logic ov(input bit s);
    return s ? b256.out_valid : b128.out_valid;
  endfunction

  function automatic logic ir(input bit s);
    return s ? b256.in_ready : b128.in_ready;
  endfunction

  function automatic logic bz(input bit s);
    return s ? b256.busy : b128.busy;
  endfunction

  function automatic logic [127:0] ct(input bit s);
    logic [127:0] r;
    r = s ? b256.ciphertext : b128.ciphertext;
    return r;
  endfunction

  // Called #1 after the accept edge; counts edges until out_valid, optionally
  // scrambling the inputs (with in_valid high) while the block is in flight.
  task automatic wait_done(input bit s, input bit scramble, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ov(s)) begin
        lat = k;
        set_in(s, 1'b0, '0, '0);
        break;
      end
      if (scramble)
        set_in(s, 1'b1,
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  task automatic run_vec(input vec_t v, input bit scramble);
    int lat;
    int nre;
    nre = v.is256 ? 14 : 10;
    @(negedge clk);
    check("in_ready_idle", 128'(ir(v.is256)), 128'd1);
    set_in(v.is256, 1'b1, v.key, v.pt);
    @(posedge clk);
    #1;
    set_in(v.is256, 1'b0, '0, '0);
    check("busy_in_round", 128'(bz(v.is256)), 128'd1);
    check("in_ready_in_round", 128'(ir(v.is256)), 128'd0);
    wait_done(v.is256, scramble, lat);
    check("latency", 128'(lat), 128'(nre));
    check("ciphertext", ct(v.is256), v.ct);
    @(posedge clk);
    #1;
    check("out_valid_after_handshake", 128'(ov(v.is256)), 128'd0);
  endtask

  initial begin
    int lat;
    int spurious;
    checks   = 0;
    failures = 0;

    tbl[0] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
               128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    tbl[1] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
               128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[2] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
    tbl[3] = '{1'b0, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    tbl[4] = '{1'b1, 256'h0, 128'h0, 128'hdc95c078a2408989ad48a21492842087};

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, '0, '0);
    set_in(1'b1, 1'b0, '0, '0);
    set_or(1'b0, 1'b1);
    set_or(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_in_ready", 128'(ir(s[0])), 128'd1);
      check("reset_out_valid", 128'(ov(s[0])), 128'd0);
      check("reset_busy", 128'(bz(s[0])), 128'd0);
      check("reset_ciphertext", ct(s[0]), 128'h0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(tbl[i], 1'b0);

    // Back-pressure: result held in DONE, then hand-off and accept on one edge.
    set_or(1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b1, tbl[0].key, tbl[0].pt);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, '0, '0);
    wait_done(1'b0, 1'b0, lat);
    check("bp_latency", 128'(lat), 128'd10);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid_held", 128'(ov(1'b0)), 128'd1);
      check("bp_ciphertext_held", ct(1'b0), tbl[0].ct);
      check("bp_in_ready_low", 128'(ir(1'b0)), 128'd0);
    end
    @(negedge clk);
    set_or(1'b0, 1'b1);
    set_in(1'b0, 1'b1, tbl[1].key, tbl[1].pt);
    #1;
    check("bp_in_ready_with_out_ready", 128'(ir(1'b0)), 128'd1);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, '0, '0);
    check("bp_same_edge_accept_busy", 128'(bz(1'b0)), 128'd1);
    check("bp_same_edge_out_valid", 128'(ov(1'b0)), 128'd0);
    wait_done(1'b0, 1'b0, lat);
    check("bp_next_latency", 128'(lat), 128'd10);
    check("bp_next_ciphertext", ct(1'b0), tbl[1].ct);
    @(posedge clk);
    #1;

    // Inputs changed while rounds run must not disturb the result.
    run_vec(tbl[2], 1'b1);
    run_vec(tbl[0], 1'b1);

    // Reset while the AES-128 instance is at round 5.
    @(negedge clk);
    set_in(1'b0, 1'b1, tbl[0].key, tbl[0].pt);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 128'(ov(1'b0)), 128'd0);
    check("midreset_busy", 128'(bz(1'b0)), 128'd0);
    check("midreset_ciphertext", ct(1'b0), 128'h0);
    check("midreset_in_ready", 128'(ir(1'b0)), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ov(1'b0)) spurious++;
    end
    check("midreset_no_out_valid", 128'(spurious), 128'd0);
    run_vec(tbl[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
